riscv_fetch_ctrl: RTL and testbench
===================================

// Module: riscv_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the pipelined RV32 core: owns the architectural PC,
//  issues one-at-a-time requests to instruction memory, presents the fetched word to IF/ID,
//  and applies EX/MEM branch/jump redirects, discarding stale in-flight fetches.
//  Sits between the hazard unit (stall), EX/MEM redirect logic and the imem port.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset, asynchronous, active-high
//  stall_i        in   1   hazard unit: IF/ID must hold; slot not consumed
//  redirect_i     in   1   one-cycle pulse: taken branch/jump resolved in EX/MEM
//  redirect_pc_i  in   32  redirect target
//  imem_req_o     out  1   fetch request valid
//  imem_addr_o    out  32  fetch address, = pc register
//  imem_gnt_i     in   1   request accepted this cycle (sampled only when imem_req_o=1)
//  imem_rvalid_i  in   1   response valid, >=1 cycle after gnt, exactly one per gnt
//  imem_rdata_i   in   32  response instruction word
//  if_valid_o     out  1   slot holds a valid instruction for IF/ID
//  if_pc_o        out  32  PC of slot instruction
//  if_inst_o      out  32  slot instruction word
//  flush_o        out  1   flush IF/ID and ID/EX; combinational, = redirect_i
//  misalign_o     out  1   FETCH_MISALIGN_TRAP_EN only: misaligned redirect (1 cycle)
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=REQ, if_valid_o=0, if_pc_o=0, if_inst_o=0, misalign_o=0;
//   imem_req_o=0 during rst, high first cycle after release.
//  slot_free = !if_valid_o | !stall_i.  Slot consumed on edge when if_valid_o & !stall_i.
//  FSM:
//   REQ : imem_req_o = slot_free. On req&gnt: pend_pc<=pc, pc<=pc+4, ->WAIT.
//         req may drop without gnt; addr stable while req high.
//   WAIT: on rvalid: if_valid_o<=1, if_inst_o<=rdata, if_pc_o<=pend_pc, ->REQ.
//   DROP: stale request outstanding; on rvalid discard data, ->REQ.
//  Redirect (priority over stall and all FSM moves), cycle t:
//   pc<=redirect_pc_i; if_valid_o<=0; flush_o=1 at t.
//   REQ with gnt at t, or WAIT without rvalid at t -> DROP.
//   WAIT with rvalid at t -> response discarded, ->REQ.  DROP stays DROP (rvalid at t
//   still ends DROP ->REQ).  REQ without gnt -> REQ, new addr at t+1.
//  Guarantee: slot is empty whenever rvalid arrives in WAIT (grant only when slot_free).
//  Latency: redirect t -> req at new PC t+1 (if not DROP); gnt t+1, rvalid t+2 ->
//   if_valid_o t+3.  Best-case throughput 1 instruction / 2 cycles.
//  pc+4 wraps modulo 2^32. Stall never alters pc or FSM except via slot_free gating.
//  Async reset mid-transaction: all state cleared; a response arriving after reset
//   release while in REQ is ignored (rvalid has no effect outside WAIT/DROP).
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc_i[1:0]!=0 sets misalign_o=1
//   for one cycle (t+1), still flushes, pc<=redirect_pc_i&~3, FSM handled as normal
//   redirect. Undefined: port absent, low bits passed through unchanged to pc.
// TESTING
//  Reset release, gnt same cycle, rvalid +1, stall_i=0 -> addrs 0,4,8; if_pc_o 0,4,8, valid
//   pulses every 2 cycles.
//  stall_i=1 with if_valid_o=1 for 5 cycles -> imem_req_o=0, slot/pc held; release -> req.
//  Redirect to 0x100 while WAIT (no rvalid) -> DROP; stale rvalid discarded; next req
//   addr 0x100; if_pc_o=0x100 next valid.
//  Redirect to 0x200 same cycle as rvalid, stall_i=1 -> flush_o=1, data dropped,
//   if_valid_o=0, req addr 0x200 next cycle.
//  pc=0xFFFF_FFFC granted -> next addr 0x0000_0000.
//  FETCH_MISALIGN_TRAP_EN: redirect to 0x102 -> misalign_o pulse, next addr 0x100.

Source files
------------

// File: rtl/riscv_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one outstanding imem request at a time,
// fills the IF/ID slot and squashes stale fetches on redirect. Option: FETCH_MISALIGN_TRAP_EN.
module riscv_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        flush_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] pc_reg;
  logic [31:0] pend_pc_reg;
  logic        if_valid_reg;
  logic [31:0] if_pc_reg;
  logic [31:0] if_inst_reg;
  logic [31:0] target_pc;
  logic        slot_free;
  logic        fire;
  logic        rsp_take;

  // A grant is only possible while the slot is free, so a WAIT response always finds it empty.
  assign slot_free = !if_valid_reg || !stall_i;
  assign fire      = imem_req_o && imem_gnt_i;
  assign rsp_take  = (state_reg == ST_WAIT) && imem_rvalid_i && !redirect_i;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_pc = {redirect_pc_i[31:2], 2'b00};
`else
  assign target_pc = redirect_pc_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_REQ;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_REQ: begin
        if (fire) begin
          state_next = redirect_i ? ST_DROP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_next = ST_REQ;
        end else if (redirect_i) begin
          state_next = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_rvalid_i) begin
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_REQ;
    endcase
  end

  always_comb begin
    imem_req_o = !rst && (state_reg == ST_REQ) && slot_free;
    flush_o    = redirect_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg      <= RESET_PC;
      pend_pc_reg <= '0;
    end else if (redirect_i) begin
      pc_reg <= target_pc;
    end else if (fire) begin
      pend_pc_reg <= pc_reg;
      pc_reg      <= pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid_reg <= 1'b0;
      if_pc_reg    <= '0;
      if_inst_reg  <= '0;
    end else if (redirect_i) begin
      if_valid_reg <= 1'b0;
    end else if (rsp_take) begin
      if_valid_reg <= 1'b1;
      if_pc_reg    <= pend_pc_reg;
      if_inst_reg  <= imem_rdata_i;
    end else if (if_valid_reg && !stall_i) begin
      if_valid_reg <= 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
    end
  end

  assign misalign_o = misalign_reg;
`endif

  assign imem_addr_o = pc_reg;
  assign if_valid_o  = if_valid_reg;
  assign if_pc_o     = if_pc_reg;
  assign if_inst_o   = if_inst_reg;

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Directed bench for riscv_fetch_ctrl: cycle-driven imem responder, reference slot/PC model
// and a scoreboard queue of expected IF/ID slot contents.
module tb_riscv_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        flush_o;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  always #5 clk = ~clk;

  riscv_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_inst_o     (if_inst_o),
    .flush_o       (flush_o)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } slot_t;

  slot_t       sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        exp_valid, load_flag, outstanding, rsp_stale, exp_mis, gnt_en, req_seen;
  logic [31:0] exp_pc, rsp_addr, exp_slot_pc, exp_slot_inst;
  int          rsp_wait, rsp_delay;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] a);
`ifdef FETCH_MISALIGN_TRAP_EN
    return {a[31:2], 2'b00};
`else
    return a;
`endif
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_valid   = 1'b0;
    load_flag   = 1'b0;
    outstanding = 1'b0;
    rsp_stale   = 1'b0;
    exp_mis     = 1'b0;
    exp_pc      = 32'h0000_0000;
    rsp_wait    = 0;
    sb_q.delete();
  endtask

  // One clock cycle: check registered outputs, drive inputs, play imem, advance the model.
  task automatic cyc(input logic stall, input logic redir, input logic [31:0] rpc,
                     input logic hold, input logic stray);
    logic  nv;
    slot_t s;
    if (load_flag) begin
      if (sb_q.size() == 0) begin
        chk1("sb_empty", 1'b1, 1'b0);
      end else begin
        s = sb_q.pop_front();
        exp_slot_pc   = s.pc;
        exp_slot_inst = s.inst;
      end
      load_flag = 1'b0;
    end
    chk1("if_valid", if_valid_o, exp_valid);
    if (exp_valid) begin
      chk32("if_pc", if_pc_o, exp_slot_pc);
      chk32("if_inst", if_inst_o, exp_slot_inst);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("misalign", misalign_o, exp_mis);
`endif
    stall_i       = stall;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    if (outstanding && rsp_wait == 0 && !hold) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = inst_of(rsp_addr);
    end else if (stray && !outstanding) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    req_seen   = imem_req_o;
    imem_gnt_i = imem_req_o && gnt_en;
    #1;
    chk1("flush", flush_o, redir);
    if (outstanding) chk1("req_idle", imem_req_o, 1'b0);
    if (imem_gnt_i) chk32("addr", imem_addr_o, exp_pc);

    nv = exp_valid && stall;
    if (outstanding && imem_rvalid_i) begin
      if (!redir && !rsp_stale) begin
        sb_q.push_back('{pc: rsp_addr, inst: inst_of(rsp_addr)});
        nv        = 1'b1;
        load_flag = 1'b1;
      end
      outstanding = 1'b0;
    end else if (outstanding) begin
      if (rsp_wait > 0 && !hold) rsp_wait--;
      if (redir) rsp_stale = 1'b1;
    end
    if (imem_gnt_i) begin
      outstanding = 1'b1;
      rsp_addr    = exp_pc;
      rsp_wait    = rsp_delay;
      rsp_stale   = redir;
    end
    if (redir) begin
      nv     = 1'b0;
      exp_pc = align_pc(rpc);
    end else if (imem_gnt_i) begin
      exp_pc = exp_pc + 32'd4;
    end
    exp_mis   = redir && (rpc[1:0] != 2'b00);
    exp_valid = nv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] mis_exp;
    rst           = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    gnt_en        = 1'b1;
    rsp_delay     = 0;
    req_seen      = 1'b0;
    exp_slot_pc   = 32'h0;
    exp_slot_inst = 32'h0;
    rsp_addr      = 32'h0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_req", imem_req_o, 1'b0);
    chk1("rst_valid", if_valid_o, 1'b0);
    chk32("rst_if_pc", if_pc_o, 32'h0);
    chk32("rst_if_inst", if_inst_o, 32'h0);
    rst = 1'b0;

    // Back-to-back fetches: 0,4,8,... with gnt same cycle, rvalid +1
    cyc(0, 0, 32'h0, 0, 0);
    chk1("req_after_rst", req_seen, 1'b1);
    repeat (7) cyc(0, 0, 32'h0, 0, 0);
    $display("step: streaming fetches done, next pc %h", exp_pc);

    // Stall with a full slot holds request and PC
    for (int g = 0; g < 10 && !exp_valid; g++) cyc(0, 0, 32'h0, 0, 0);
    chk1("stall_reach_valid", if_valid_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 32'h0, 0, 0);
      chk1("stall_req", imem_req_o, 1'b0);
      chk32("stall_addr", imem_addr_o, exp_pc);
    end
    cyc(0, 0, 32'h0, 0, 0);
    chk1("stall_release_req", req_seen, 1'b1);
    $display("step: stall hold/release done");

    // Redirect while waiting for a slow response: stale data discarded
    rsp_delay = 3;
    for (int g = 0; g < 10 && !outstanding; g++) cyc(0, 0, 32'h0, 0, 0);
    cyc(0, 1, 32'h0000_0100, 0, 0);
    for (int g = 0; g < 20 && !exp_valid; g++) cyc(0, 0, 32'h0, 0, 0);
    chk1("drop_valid", if_valid_o, 1'b1);
    chk32("drop_if_pc", if_pc_o, 32'h0000_0100);
    $display("step: redirect in WAIT to 100 done");

    // Redirect on the same cycle as rvalid, with stall asserted
    rsp_delay = 0;
    for (int g = 0; g < 10 && !(outstanding && rsp_wait == 0); g++) cyc(0, 0, 32'h0, 0, 0);
    cyc(1, 1, 32'h0000_0200, 0, 0);
    chk1("rv_redir_valid", if_valid_o, 1'b0);
    chk1("rv_redir_req", imem_req_o, 1'b1);
    chk32("rv_redir_addr", imem_addr_o, 32'h0000_0200);
    repeat (4) cyc(0, 0, 32'h0, 0, 0);
    $display("step: redirect with rvalid to 200 done");

    // PC wrap from 0xFFFF_FFFC
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0);
    for (int g = 0; g < 20 && !(outstanding && rsp_addr == 32'hFFFF_FFFC); g++)
      cyc(0, 0, 32'h0, 0, 0);
    chk32("wrap_addr", imem_addr_o, 32'h0000_0000);
    repeat (4) cyc(0, 0, 32'h0, 0, 0);
    $display("step: pc wrap done");

    // Redirect with nonzero low bits
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_exp = 32'h0000_0100;
`else
    mis_exp = 32'h0000_0102;
`endif
    cyc(0, 1, 32'h0000_0102, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("misalign_pulse", misalign_o, 1'b1);
`endif
    for (int g = 0; g < 20 && !exp_valid; g++) cyc(0, 0, 32'h0, 0, 0);
    chk32("mis_if_pc", if_pc_o, mis_exp);
    $display("step: low-bit redirect done, if_pc %h", if_pc_o);

    // Async reset mid-transaction, then a stray response in REQ is ignored
    rsp_delay = 2;
    for (int g = 0; g < 10 && !outstanding; g++) cyc(0, 0, 32'h0, 0, 0);
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_gnt_i    = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk1("arst_valid", if_valid_o, 1'b0);
    chk1("arst_req", imem_req_o, 1'b0);
    chk32("arst_addr", imem_addr_o, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    gnt_en = 1'b0;
    cyc(0, 0, 32'h0, 0, 1);
    chk1("stray_valid", if_valid_o, 1'b0);
    chk1("stray_req", imem_req_o, 1'b1);
    gnt_en = 1'b1;
    repeat (8) cyc(0, 0, 32'h0, 0, 0);
    $display("step: async reset and stray response done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
